// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned MEM_LAT_DEFAULT = 4;

    // Line refills are 8-byte aligned, write-through words 4-byte aligned.
    function automatic logic [31:0] mem_align(input logic [31:0] addr, input logic we);
        return we ? {addr[31:2], 2'b00} : {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Memory latency down-counter: load on transaction start, count down to zero.
module lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between I and D caches.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [63:0] rdata,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t     state, state_nx;
    owner_t     owner, last_grant, grant;
    logic       start, finish;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [3:0] cnt;

    lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_INIT),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant    = OWN_I;
        start    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    start    = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = ST_BUSY;
                    if (i_req && d_req) grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
                    else                grant = d_req ? OWN_D : OWN_I;
                end
            end
            ST_BUSY: begin
                if (cnt_zero) state_nx = ST_DONE;
                else          cnt_dec  = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
        finish = (state == ST_BUSY) && cnt_zero;
    end

    // Memory-side outputs are loaded on grant and cleared as BUSY ends,
    // so mem_we also tells us at the final edge whether to capture rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            busy       <= 1'b0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            busy   <= (state_nx != ST_IDLE);
            i_done <= finish && (owner == OWN_I);
            d_done <= finish && (owner == OWN_D);
            if (start) begin
                owner      <= grant;
                last_grant <= grant;
                mem_en     <= 1'b1;
                if (grant == OWN_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= mem_align(d_addr, d_we);
                    mem_wdata <= d_we ? d_wdata : '0;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= mem_align(i_addr, 1'b0);
                    mem_wdata <= '0;
                end
            end else if (finish) begin
                if (!mem_we) rdata <= mem_rdata;
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level queue model plus directed literal checks.
module tb_mem_arbiter;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [63:0] mem_rdata = '0;

    logic        i_done, d_done, busy, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [63:0] rdata;

    logic        l1_i_done, l1_d_done, l1_busy, l1_mem_en, l1_mem_we;
    logic [31:0] l1_mem_addr, l1_mem_wdata;
    logic [63:0] l1_rdata;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(l1_i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(l1_d_done),
        .rdata(l1_rdata), .busy(l1_busy),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: one record per future cycle ----------------
    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        idn;
        logic        ddn;
        logic        latch;
    } rec_t;

    rec_t        q[$];
    rec_t        exp_r = '0;
    rec_t        r;
    logic [63:0] exp_rdata = '0;
    logic        m_last_d = 1'b0;
    logic        pick_d;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_r     = '0;
            exp_rdata = '0;
            m_last_d  = 1'b0;
        end else begin
            if (q.size() == 0) begin
                if (i_req || d_req) begin
                    pick_d   = d_req && (!i_req || !m_last_d);
                    m_last_d = pick_d;
                    r        = '0;
                    r.en     = 1'b1;
                    r.busy   = 1'b1;
                    r.we     = pick_d && d_we;
                    if (pick_d) r.addr = d_we ? (d_addr & ~32'h3) : (d_addr & ~32'h7);
                    else        r.addr = i_addr & ~32'h7;
                    r.wdata  = r.we ? d_wdata : 32'h0;
                    for (int n = 0; n < int'(LAT); n++) q.push_back(r);
                    r.latch  = !r.we;
                    r.en     = 1'b0;
                    r.we     = 1'b0;
                    r.addr   = '0;
                    r.wdata  = '0;
                    r.idn    = !pick_d;
                    r.ddn    = pick_d;
                    q.push_back(r);
                    q.push_back(rec_t'('0));
                end else begin
                    q.push_back(rec_t'('0));
                end
            end
            exp_r = q.pop_front();
            if (exp_r.latch) exp_rdata = mem_rdata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("m_mem_en",    64'(mem_en),    64'(exp_r.en));
            chk("m_mem_we",    64'(mem_we),    64'(exp_r.we));
            chk("m_mem_addr",  64'(mem_addr),  64'(exp_r.addr));
            chk("m_mem_wdata", 64'(mem_wdata), 64'(exp_r.wdata));
            chk("m_busy",      64'(busy),      64'(exp_r.busy));
            chk("m_i_done",    64'(i_done),    64'(exp_r.idn));
            chk("m_d_done",    64'(d_done),    64'(exp_r.ddn));
            chk("m_rdata",     rdata,          exp_rdata);
            chk("done_excl",   64'(i_done & d_done), 64'h0);
        end
    end

    // ---------------- directed sequences ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] ea;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_rdata",  rdata,       64'h0);
        chk("rst_addr",   64'(mem_addr), 64'h0);
        rst = 1'b1;

        // Single I refill
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h104; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t1_en_%0d", k),   64'(mem_en),   64'((k >= 1 && k <= 4) ? 1 : 0));
            chk($sformatf("t1_addr_%0d", k), 64'(mem_addr), (k <= 4) ? 64'h100 : 64'h0);
            chk($sformatf("t1_idn_%0d", k),  64'(i_done),   64'((k == 5) ? 1 : 0));
            if (k == 5) begin
                chk("t1_rdata", rdata, 64'hAAAA_BBBB_CCCC_DDDD);
                @(negedge clk);
                i_req = 1'b0;
            end
        end

        // Conflict after reset: D, I, D with both held
        do_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h1010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2028;
        mem_rdata = 64'h1111_2222_3333_4444;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if ((k >= 1 && k <= 4) || (k >= 13 && k <= 16)) ea = 32'h2028;
            else if (k >= 7 && k <= 10)                     ea = 32'h1010;
            else                                             ea = 32'h0;
            chk($sformatf("t2_en_%0d", k),   64'(mem_en), 64'((ea != 0) ? 1 : 0));
            chk($sformatf("t2_addr_%0d", k), 64'(mem_addr), 64'(ea));
            chk($sformatf("t2_busy_%0d", k), 64'(busy),   64'((k == 6 || k == 12) ? 0 : 1));
            chk($sformatf("t2_ddn_%0d", k),  64'(d_done), 64'((k == 5 || k == 17) ? 1 : 0));
            chk($sformatf("t2_idn_%0d", k),  64'(i_done), 64'((k == 11) ? 1 : 0));
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // D write-through
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2007; d_wdata = 32'h1234_5678;
        mem_rdata = 64'hDEAD_BEEF_0000_0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t3_we_%0d", k),   64'(mem_we),    64'((k <= 4) ? 1 : 0));
            chk($sformatf("t3_addr_%0d", k), 64'(mem_addr),  (k <= 4) ? 64'h2004 : 64'h0);
            chk($sformatf("t3_wd_%0d", k),   64'(mem_wdata), (k <= 4) ? 64'h1234_5678 : 64'h0);
            chk($sformatf("t3_ddn_%0d", k),  64'(d_done),    64'((k == 5) ? 1 : 0));
            chk($sformatf("t3_rd_%0d", k),   rdata,          64'h1111_2222_3333_4444);
            if (k == 5) begin
                @(negedge clk);
                d_req = 1'b0; d_we = 1'b0;
            end
        end

        // Reset in the second BUSY cycle of a D read, then regrant
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; mem_rdata = 64'h5555_6666_7777_8888;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t4_en_async",   64'(mem_en),   64'h0);
        chk("t4_busy_async", 64'(busy),     64'h0);
        chk("t4_addr_async", 64'(mem_addr), 64'h0);
        repeat (3) begin
            tick();
            chk("t4_ddn_in_rst", 64'(d_done), 64'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t4_en_%0d", k),  64'(mem_en), 64'((k <= 4) ? 1 : 0));
            chk($sformatf("t4_ddn_%0d", k), 64'(d_done), 64'((k == 5) ? 1 : 0));
            if (k == 5) begin
                chk("t4_rdata", rdata, 64'h5555_6666_7777_8888);
                @(negedge clk);
                d_req = 1'b0;
            end
        end

        // MEM_LAT=1 instance, single I read
        do_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40C; mem_rdata = 64'h0123_4567_89AB_CDEF;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("t5_en_%0d", k),  64'(l1_mem_en), 64'((k == 1) ? 1 : 0));
            chk($sformatf("t5_idn_%0d", k), 64'(l1_i_done), 64'((k == 2) ? 1 : 0));
            if (k == 1) chk("t5_addr", 64'(l1_mem_addr), 64'h408);
            if (k == 2) begin
                chk("t5_rdata", l1_rdata, 64'h0123_4567_89AB_CDEF);
                @(negedge clk);
                i_req = 1'b0;
            end
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_req     = ($urandom_range(0, 3) != 0);
            d_req     = ($urandom_range(0, 3) != 0);
            d_we      = $urandom_range(0, 1) == 1;
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
